// File: rtl/foc_sample_scheduler.sv
// foc_sample_scheduler: per-PWM-period sequencer for current sampling,
// encoder angle read and FOC computation, with per-phase timeout.
// Ports:
//   I_clk_40m, I_rst (async, active-high), I_en (level enable)
//   I_pwm_trig     period trigger pulse
//   O_adc_start / I_adc_done    phase-current conversion handshake
//   O_ang_start / I_ang_done    encoder angle read handshake
//   O_calc_start / I_calc_done  FOC computation handshake
//   O_busy, O_overrun (pulse), O_timeout_err (sticky), I_err_clr
//   O_phase        current state (IDLE=0 WAIT=1 ADC=2 ANG=3 CALC=4)
//   O_overrun_cnt  saturating overrun count, only with FOC_SCHED_STATS_EN
module foc_sample_scheduler #(
    parameter int TIMEOUT_CYC = 4000,
    parameter int ANGLE_DIV   = 1
) (
    input  logic       I_clk_40m,
    input  logic       I_rst,
    input  logic       I_en,
    input  logic       I_pwm_trig,
    output logic       O_adc_start,
    input  logic       I_adc_done,
    output logic       O_ang_start,
    input  logic       I_ang_done,
    output logic       O_calc_start,
    input  logic       I_calc_done,
    output logic       O_busy,
    output logic       O_overrun,
    output logic       O_timeout_err,
    input  logic       I_err_clr,
    output logic [2:0] O_phase
`ifdef FOC_SCHED_STATS_EN
    ,
    output logic [15:0] O_overrun_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ADC  = 3'd2,
        S_ANG  = 3'd3,
        S_CALC = 3'd4
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] PLAST = 8'(ANGLE_DIV - 1);

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    pcnt_q;
    logic          ang_due_q;
    logic          busy;
    logic          tmo;
    logic          trig_acc;
    logic          adc_d;
    logic          ang_d;
    logic          calc_d;
    logic          ovr_d;
    logic          err_set;

    assign busy    = (state_q == S_ADC) || (state_q == S_ANG) ||
                     (state_q == S_CALC);
    assign tmo     = (tcnt_q == TLIM);
    assign O_busy  = busy;
    assign O_phase = state_q;

    // Done is tested before the timeout so a done arriving on the last
    // allowed cycle still takes the normal path.
    always_comb begin
        state_d  = state_q;
        trig_acc = 1'b0;
        adc_d    = 1'b0;
        ang_d    = 1'b0;
        calc_d   = 1'b0;
        ovr_d    = 1'b0;
        err_set  = 1'b0;
        if (!I_en) begin
            state_d = S_IDLE;
        end else begin
            ovr_d = busy & I_pwm_trig;
            unique case (state_q)
                S_IDLE: state_d = S_WAIT;
                S_WAIT: begin
                    if (I_pwm_trig) begin
                        state_d  = S_ADC;
                        adc_d    = 1'b1;
                        trig_acc = 1'b1;
                    end
                end
                S_ADC: begin
                    if (I_adc_done) begin
                        if (ang_due_q) begin
                            state_d = S_ANG;
                            ang_d   = 1'b1;
                        end else begin
                            state_d = S_CALC;
                            calc_d  = 1'b1;
                        end
                    end else if (tmo) begin
                        state_d = S_WAIT;
                        err_set = 1'b1;
                    end
                end
                S_ANG: begin
                    if (I_ang_done) begin
                        state_d = S_CALC;
                        calc_d  = 1'b1;
                    end else if (tmo) begin
                        state_d = S_WAIT;
                        err_set = 1'b1;
                    end
                end
                S_CALC: begin
                    if (I_calc_done) begin
                        state_d = S_WAIT;
                    end else if (tmo) begin
                        state_d = S_WAIT;
                        err_set = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk_40m or posedge I_rst) begin
        if (I_rst) begin
            state_q       <= S_IDLE;
            tcnt_q        <= '0;
            pcnt_q        <= '0;
            ang_due_q     <= 1'b0;
            O_adc_start   <= 1'b0;
            O_ang_start   <= 1'b0;
            O_calc_start  <= 1'b0;
            O_overrun     <= 1'b0;
            O_timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                tcnt_q <= '0;
            end else if (busy) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            // The angle decision is latched from the pre-advance count so
            // the first trigger after reset reads the angle.
            if (trig_acc) begin
                ang_due_q <= (pcnt_q == 8'd0);
                pcnt_q    <= (pcnt_q == PLAST) ? 8'd0 : pcnt_q + 1'b1;
            end
            O_adc_start  <= adc_d;
            O_ang_start  <= ang_d;
            O_calc_start <= calc_d;
            O_overrun    <= ovr_d;
            if (err_set) begin
                O_timeout_err <= 1'b1;
            end else if (I_err_clr) begin
                O_timeout_err <= 1'b0;
            end
        end
    end

`ifdef FOC_SCHED_STATS_EN
    // Counts at the same edge that raises O_overrun, so the new value is
    // visible together with the pulse.
    always_ff @(posedge I_clk_40m or posedge I_rst) begin
        if (I_rst) begin
            O_overrun_cnt <= '0;
        end else if (I_err_clr) begin
            O_overrun_cnt <= '0;
        end else if (ovr_d && (O_overrun_cnt != 16'hFFFF)) begin
            O_overrun_cnt <= O_overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_foc_sample_scheduler.sv
// tb_foc_sample_scheduler: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the scheduler.
module tb_foc_sample_scheduler;

    localparam int TO  = 256;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst, en, trig, adc_done, ang_done, calc_done, err_clr;
    logic adc_start, ang_start, calc_start, busy, ovr, err;
    logic [2:0] phase;
`ifdef FOC_SCHED_STATS_EN
    logic [15:0] ocnt;
`endif

    int total = 0;
    int bad   = 0;
    bit stop  = 0;

    always #5 clk = ~clk;

    foc_sample_scheduler #(.TIMEOUT_CYC(TO), .ANGLE_DIV(DIV)) dut (
        .I_clk_40m    (clk),
        .I_rst        (rst),
        .I_en         (en),
        .I_pwm_trig   (trig),
        .O_adc_start  (adc_start),
        .I_adc_done   (adc_done),
        .O_ang_start  (ang_start),
        .I_ang_done   (ang_done),
        .O_calc_start (calc_start),
        .I_calc_done  (calc_done),
        .O_busy       (busy),
        .O_overrun    (ovr),
        .O_timeout_err(err),
        .I_err_clr    (err_clr),
        .O_phase      (phase)
`ifdef FOC_SCHED_STATS_EN
        ,
        .O_overrun_cnt(ocnt)
`endif
    );

    // Behavioural model: phase as a plain integer, time spent in the
    // current phase, and the number of accepted triggers so far.
    typedef struct packed {
        int ph;
        int cyc;
        int trigs;
        bit due;
        bit adc;
        bit ang;
        bit calc;
        bit ovr;
        bit err;
        int ocnt;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t next_mdl(mdl_t c);
        mdl_t n;
        int   np;
        bit   bz;
        bit   set;
        n      = c;
        n.adc  = 0;
        n.ang  = 0;
        n.calc = 0;
        n.ovr  = 0;
        set    = 0;
        np     = c.ph;
        bz     = (c.ph >= 2);
        if (!en) begin
            np = 0;
        end else begin
            n.ovr = bz && trig;
            if (c.ph == 0) begin
                np = 1;
            end else if (c.ph == 1) begin
                if (trig) begin
                    np      = 2;
                    n.adc   = 1;
                    n.due   = (c.trigs % DIV) == 0;
                    n.trigs = c.trigs + 1;
                end
            end else if (c.ph == 2 && adc_done) begin
                np     = c.due ? 3 : 4;
                n.ang  = c.due;
                n.calc = !c.due;
            end else if (c.ph == 3 && ang_done) begin
                np     = 4;
                n.calc = 1;
            end else if (c.ph == 4 && calc_done) begin
                np = 1;
            end else if (bz && c.cyc == TO - 1) begin
                np  = 1;
                set = 1;
            end
        end
        n.err = set ? 1'b1 : (err_clr ? 1'b0 : c.err);
        if (err_clr) n.ocnt = 0;
        else if (n.ovr && c.ocnt < 65535) n.ocnt = c.ocnt + 1;
        n.cyc = (np != c.ph) ? 0 : c.cyc + 1;
        n.ph  = np;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= next_mdl(m);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; trig = 0; err_clr = 0;
        adc_done = 0; ang_done = 0; calc_done = 0;
        step();
        step();
        chk("reset_outputs",
            {phase, busy, adc_start, ang_start, calc_start, ovr, err}, 0);
        rst = 0;
    endtask

    // Fires a trigger and answers each start pulse with its done after the
    // given number of cycles (0 = same cycle the pulse is seen).
    task automatic serve(input int la, input int lb, input int lc,
                         input int xk, output int nb, output int ka,
                         output int kb, output int kc, output int nov,
                         output int nadc);
        int ca, cb, cc;
        bit fin;
        ca = -1; cb = -1; cc = -1; fin = 0;
        nb = 0; ka = -1; kb = -1; kc = -1; nov = 0; nadc = 0;
        trig = 1;
        step();
        trig = 0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            if (!busy && k > 0) begin
                fin = 1;
            end else begin
                if (adc_start) begin
                    nadc++;
                    if (ka < 0) ka = k;
                    ca = la;
                end
                if (ang_start) begin
                    if (kb < 0) kb = k;
                    cb = lb;
                end
                if (calc_start) begin
                    if (kc < 0) kc = k;
                    cc = lc;
                end
                if (ovr)  nov++;
                if (busy) nb++;
                adc_done  = (ca == 0);
                ang_done  = (cb == 0);
                calc_done = (cc == 0);
                trig      = (k == xk);
                if (ca >= 0) ca--;
                if (cb >= 0) cb--;
                if (cc >= 0) cc--;
                step();
            end
        end
        adc_done = 0; ang_done = 0; calc_done = 0; trig = 0;
        if (!fin) chk("serve_bound", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ka, kb, kc, nov, nadc, ke, pe, nc, n_after;
        logic [7:0] pat;
        logic       e_at, e_next;
        do_reset();
        fork
            while (!stop) begin
                @(negedge clk);
                if (!stop) begin
                    chk("model_cmp",
                        {phase, busy, adc_start, ang_start, calc_start,
                         ovr, err},
                        {3'(m.ph), m.ph >= 2, m.adc, m.ang, m.calc,
                         m.ovr, m.err});
`ifdef FOC_SCHED_STATS_EN
                    chk("model_ocnt", ocnt, m.ocnt);
`endif
                end
            end
            begin
                en = 1;
                step();
                chk("wait_after_release", phase, 1);

                // chained done latencies 50 / 200 / 100 from adc_start
                serve(50, 199, 99, -1, nb, ka, kb, kc, nov, nadc);
                chk("s1_busy_cycles", nb, 351);
                chk("s1_adc_at", ka, 0);
                chk("s1_ang_at", kb, 51);
                chk("s1_calc_at", kc, 251);

                do_reset();
                en = 1;
                step();
                pat = '0;
                for (int i = 0; i < 8; i++) begin
                    serve($urandom_range(0, 5), $urandom_range(0, 5),
                          $urandom_range(0, 5), -1, nb, ka, kb, kc, nov,
                          nadc);
                    pat[i] = (kb >= 0);
                end
                chk("s2_ang_pattern", pat, 8'h11);

                do_reset();
                en = 1;
                step();
                trig = 1;
                step();
                trig = 0;
                ke = -1; pe = -1; nc = 0; e_at = 0; e_next = 0;
                for (int k = 0; k < TO + 4; k++) begin
                    if (err && ke < 0) begin
                        ke = k;
                        pe = phase;
                    end
                    if (calc_start || ang_start) nc++;
                    if (k == TO)     e_at = err;
                    if (k == TO + 1) e_next = err;
                    err_clr = (k == TO - 1) || (k == TO);
                    step();
                end
                err_clr = 0;
                chk("s3_err_cycle", ke, TO);
                chk("s3_phase_wait", pe, 1);
                chk("s3_no_start", nc, 0);
                chk("s3_set_beats_clr", e_at, 1);
                chk("s3_clr_clears", e_next, 0);

                do_reset();
                en = 1;
                step();
                serve(TO - 1, 0, 0, -1, nb, ka, kb, kc, nov, nadc);
                chk("s4_done_beats_tmo", kb, TO);
                chk("s4_no_err", err, 0);

                do_reset();
                en = 1;
                step();
                serve(3, 3, 10, 12, nb, ka, kb, kc, nov, nadc);
                chk("s5_overrun_once", nov, 1);
                chk("s5_single_adc", nadc, 1);
                n_after = 0;
                for (int k = 0; k < 10; k++) begin
                    if (adc_start) n_after++;
                    step();
                end
                chk("s5_no_queued_adc", n_after, 0);
`ifdef FOC_SCHED_STATS_EN
                chk("s5_overrun_cnt", ocnt, 1);
`endif

                do_reset();
                en = 1;
                step();
                trig = 1;
                step();
                trig = 0;
                chk("s6_adc_start", adc_start, 1);
                adc_done = 1;
                step();
                adc_done = 0;
                chk("s6_in_ang", {phase, ang_start}, 7);
                step();
                step();
                en = 0;
                step();
                chk("s6_idle_busy", {phase, busy}, 0);
                ang_done = 1;
                step();
                ang_done = 0;
                chk("s6_late_done", {phase, calc_start}, 0);
                en = 1;
                step();
                chk("s6_rearm", phase, 1);

                trig = 1;
                step();
                trig = 0;
                step();
                #2;
                rst = 1;
                #1;
                chk("s7_async_reset",
                    {phase, busy, adc_start, ang_start, calc_start, ovr, err},
                    0);
                step();
                rst = 0;
                step();
                chk("s7_after_release", phase, 1);

                for (int i = 0; i < 3000; i++) begin
                    en        = ($urandom_range(0, 99) < 97);
                    trig      = ($urandom_range(0, 99) < 12);
                    adc_done  = ($urandom_range(0, 99) < 10);
                    ang_done  = ($urandom_range(0, 99) < 10);
                    calc_done = ($urandom_range(0, 99) < 10);
                    err_clr   = ($urandom_range(0, 99) < 3);
                    step();
                end
                trig = 0; adc_done = 0; ang_done = 0; calc_done = 0;
                err_clr = 0;
                step();
                stop = 1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
